// File: rtl/debounce_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// debounce_multi
//
// Debounces WIDTH independent asynchronous inputs. Each channel passes through
// an optional synchroniser, then a stability counter: the debounced level only
// follows the synchronised input after it has disagreed with the current output
// for CYCLES consecutive clocks. A change of output produces a one-cycle
// rise/fall strobe on the same cycle the new level appears, and any_change is
// the registered OR of all strobes.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   signal_in   in   WIDTH  raw asynchronous inputs
//   signal_out  out  WIDTH  debounced levels
//   rise        out  WIDTH  one-cycle strobe, signal_out went 0->1
//   fall        out  WIDTH  one-cycle strobe, signal_out went 1->0
//   any_change  out  1      high in the cycle any rise/fall bit is high
//
// There is no valid/ready handshake: inputs are level-sampled every clock and
// the strobes are single-cycle pulses the consumer must catch when they occur.
// -----------------------------------------------------------------------------
module debounce_multi #(
    parameter int               WIDTH        = 4,
    parameter realtime          DELAY        = 10ms,
    parameter realtime          CLOCK_PERIOD = 20ns,
    parameter int               SYNC_STAGES  = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] signal_in,
    output logic [WIDTH-1:0] signal_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    // CYCLES = max(1, ceil(DELAY / CLOCK_PERIOD)); the ratio is guarded so a
    // bad CLOCK_PERIOD reaches the elaboration error instead of dividing by 0.
    localparam real RATIO  = (CLOCK_PERIOD > 0.0) ? (DELAY / CLOCK_PERIOD) : 1.0;
    localparam int  TRUNC  = $rtoi(RATIO);
    localparam int  CEIL   = (real'(TRUNC) < RATIO) ? TRUNC + 1 : TRUNC;
    localparam int  CYCLES = (CEIL < 1) ? 1 : CEIL;
    localparam int  CW     = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be 0..4");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("debounce_multi: WIDTH must be >= 1");
    end
    if (CLOCK_PERIOD <= 0.0) begin : g_bad_period
        $error("debounce_multi: CLOCK_PERIOD must be > 0");
    end

    // ---------------------------------------------------------------------
    // Synchroniser: s is the input as seen by the counters.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = signal_in;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < SYNC_STAGES; j++) begin
                    sync_q[j] <= RESET_VALUE;
                end
            end else begin
                sync_q[0] <= signal_in;
                for (int j = 1; j < SYNC_STAGES; j++) begin
                    sync_q[j] <= sync_q[j-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    // ---------------------------------------------------------------------
    // Stability counters and debounced level
    // ---------------------------------------------------------------------
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_q;

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == out_q[i]) begin
                // Agreement (including a single-cycle glitch back) restarts
                // the count, so only an unbroken run of CYCLES mismatches wins.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
                out_d[i]  = s[i];
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            out_q  <= RESET_VALUE;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            // Computed from the next-state strobes so it lines up with them.
            any_q  <= |(rise_d | fall_d);
        end
    end

    assign signal_out = out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign any_change = any_q;

endmodule
